// File: rtl/fifo_wr_arb_if.sv
// Bus bundle between two write requesters, the arbiter and a shared FIFO write port.
//   req0_valid/req0_data/req0_ready : requester 0 handshake
//   req1_valid/req1_data/req1_ready : requester 1 handshake
//   fifo_full                       : full flag from the FIFO
//   fifo_wr/fifo_data               : FIFO write strobe and data
// Modports: master = arbiter side, slave = requesters plus FIFO side.
interface fifo_wr_arb_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             fifo_full;
  logic             fifo_wr;
  logic [WIDTH-1:0] fifo_data;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, fifo_full,
    output req0_ready, req1_ready, fifo_wr, fifo_data
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, fifo_full,
    input  req0_ready, req1_ready, fifo_wr, fifo_data
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Two-requester write arbiter in front of a single FIFO write port. A grant lasts up to
// BURST words; ties are broken round-robin through last_gnt. The arbiter holds no data:
// ready, write strobe and write data are combinational from the grant state.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   bus_io    : requester handshakes and FIFO write port (master modport)
//   gnt       : one-hot grant, 01 = requester 0, 10 = requester 1, 00 = idle
//   burst_cnt : words moved in the current grant
module fifo_wr_arb #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  fifo_wr_arb_if.master   bus_io,
  output logic [1:0]      gnt,
  output logic [7:0]      burst_cnt
);

  // Encoding equals the gnt value, so the state register is the registered grant.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StGnt0 = 2'b01,
    StGnt1 = 2'b10
  } state_e;

  localparam logic [7:0] BurstLast = 8'(BURST - 1);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic       last_gnt_q;

  logic sel1;       // current grant is requester 1
  logic granted;    // in a grant state and not in reset
  logic valid_x;    // valid of the granted requester
  logic valid_y;    // valid of the other requester
  logic xfer;
  logic grant_end;

  always_comb begin
    sel1      = (state_q == StGnt1);
    granted   = (state_q != StIdle) && !rst;
    valid_x   = sel1 ? bus_io.req1_valid : bus_io.req0_valid;
    valid_y   = sel1 ? bus_io.req0_valid : bus_io.req1_valid;
    xfer      = granted && valid_x && !bus_io.fifo_full;
    // A stalled word (valid, FIFO full) does not end the grant.
    grant_end = (state_q != StIdle) && (!valid_x || (xfer && (cnt_q == BurstLast)));
  end

  // Outputs are gated by rst so a reset mid-burst drops the in-flight word at once.
  always_comb begin
    bus_io.req0_ready = xfer && !sel1;
    bus_io.req1_ready = xfer && sel1;
    bus_io.fifo_wr    = xfer;
    if (!granted) begin
      bus_io.fifo_data = '0;
    end else if (sel1) begin
      bus_io.fifo_data = bus_io.req1_data;
    end else begin
      bus_io.fifo_data = bus_io.req0_data;
    end
    gnt       = rst ? 2'b00 : state_q;
    burst_cnt = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      last_gnt_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (bus_io.req0_valid && bus_io.req1_valid) begin
            state_q    <= last_gnt_q ? StGnt0 : StGnt1;
            last_gnt_q <= !last_gnt_q;
          end else if (bus_io.req0_valid) begin
            state_q    <= StGnt0;
            last_gnt_q <= 1'b0;
          end else if (bus_io.req1_valid) begin
            state_q    <= StGnt1;
            last_gnt_q <= 1'b1;
          end
        end
        StGnt0, StGnt1: begin
          if (grant_end) begin
            cnt_q <= '0;
            if (valid_y) begin
              state_q    <= sel1 ? StGnt0 : StGnt1;
              last_gnt_q <= !sel1;
            end else if (valid_x) begin
              // Re-grant the same requester with a fresh burst.
              last_gnt_q <= sel1;
            end else begin
              state_q <= StIdle;
            end
          end else if (xfer) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
module tb_fifo_wr_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arb_if #(.WIDTH(8)) a ();
  fifo_wr_arb_if #(.WIDTH(8)) b ();
  logic [1:0] gnt_a, gnt_b;
  logic [7:0] cnt_a, cnt_b;

  fifo_wr_arb #(.WIDTH(8), .BURST(4)) u_dut_a (
    .clk(clk), .rst(rst), .bus_io(a), .gnt(gnt_a), .burst_cnt(cnt_a)
  );
  fifo_wr_arb #(.WIDTH(8), .BURST(1)) u_dut_b (
    .clk(clk), .rst(rst), .bus_io(b), .gnt(gnt_b), .burst_cnt(cnt_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] rq0[$], rq1[$], fifo_m[$], exp_a[$], exp_r[$], exp_b[$];
  logic       rd_en = 1'b0, rd_pulse = 1'b0, en_b = 1'b0;
  logic [7:0] kb0 = 8'd0, kb1 = 8'd0;
  bit         hs0, hs1, hsb0, hsb1, do_wr, do_rd;
  logic [7:0] wr_data;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void apply();
    a.req0_valid = (rq0.size() > 0);
    a.req0_data  = (rq0.size() > 0) ? rq0[0] : 8'h00;
    a.req1_valid = (rq1.size() > 0);
    a.req1_data  = (rq1.size() > 0) ? rq1[0] : 8'h00;
    a.fifo_full  = (fifo_m.size() >= 8);
    b.req0_valid = en_b && (kb0 < 8'd8);
    b.req0_data  = kb0;
    b.req1_valid = en_b && (kb1 < 8'd8);
    b.req1_data  = 8'h80 | kb1;
    b.fifo_full  = en_b && ((cyc % 5) == 3);
  endfunction

  function automatic void expect_a(input logic [7:0] w);
    exp_a.push_back(w);
    exp_r.push_back(w);
  endfunction

  // Sample handshakes mid-cycle, apply them just after the next rising edge.
  always @(negedge clk) begin
    hs0   = a.req0_valid && a.req0_ready;
    hs1   = a.req1_valid && a.req1_ready;
    hsb0  = b.req0_valid && b.req0_ready;
    hsb1  = b.req1_valid && b.req1_ready;
    do_wr = a.fifo_wr && !a.fifo_full;
    wr_data = a.fifo_data;
    do_rd = (rd_en || rd_pulse) && (fifo_m.size() > 0);
  end

  always @(posedge clk) begin
    logic [7:0] q, e;
    #1;
    cyc++;
    if (do_rd) begin
      q = fifo_m.pop_front();
      if (exp_r.size() == 0) begin
        checks++; errors++;
        $display("FAIL fifo_q got %0h expected none", q);
      end else begin
        e = exp_r.pop_front();
        chk("fifo_q", q, e);
      end
    end
    if (do_wr) fifo_m.push_back(wr_data);
    if (hs0) void'(rq0.pop_front());
    if (hs1) void'(rq1.pop_front());
    if (hsb0) kb0++;
    if (hsb1) kb1++;
    {hs0, hs1, hsb0, hsb1, do_wr, do_rd} = '0;
    apply();
  end

  // Scoreboard monitor: pops an expected word whenever a DUT writes.
  always @(negedge clk) begin
    logic [7:0] e;
    if (a.fifo_full) begin
      checks++;
      if (a.fifo_wr) begin errors++; $display("FAIL overflow_a got wr=1 expected 0"); end
    end
    if (b.fifo_full) begin
      checks++;
      if (b.fifo_wr) begin errors++; $display("FAIL overflow_b got wr=1 expected 0"); end
    end
    if (a.fifo_wr) begin
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_a got %0h expected no write", a.fifo_data);
      end else begin
        e = exp_a.pop_front();
        chk("wr_data_a", a.fifo_data, e);
      end
    end
    if (b.fifo_wr) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_b got %0h expected no write", b.fifo_data);
      end else begin
        e = exp_b.pop_front();
        chk("wr_data_b", b.fifo_data, e);
      end
    end
  end

  assert property (@(posedge clk) !(a.fifo_wr && a.fifo_full));
  assert property (@(posedge clk) !(b.fifo_wr && b.fifo_full));

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt_a, 2'b00);
    chk("rst_cnt", cnt_a, 8'd0);
    chk("rst_wr", a.fifo_wr, 1'b0);
    chk("rst_rdy", {a.req0_ready, a.req1_ready}, 2'b00);
    chk("rst_data", a.fifo_data, 8'h00);
    chk("rst_gnt_b", gnt_b, 2'b00);
    chk("drained_a", exp_r.size(), 0);
    #1;
    rq0.delete(); rq1.delete(); fifo_m.delete();
    rd_en = 1'b0;
    apply();
  endtask

  task automatic drain(input int n);
    rd_en = 1'b1;
    repeat (n) @(negedge clk);
    chk("all_written_a", exp_a.size(), 0);
    chk("all_read_a", exp_r.size(), 0);
  endtask

  initial begin
    int nw;
    apply();

    // Single requester, re-grant after a full burst.
    do_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("s1_idle_gnt", gnt_a, 2'b00);
    @(posedge clk); #2;
    rq0 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9a};
    foreach (rq0[i]) expect_a(rq0[i]);
    apply();
    @(negedge clk);
    chk("s1_idle_nowr", a.fifo_wr, 1'b0);
    chk("s1_idle_gnt2", gnt_a, 2'b00);
    @(negedge clk);
    chk("s1_gnt0", gnt_a, 2'b01);
    chk("s1_cnt0", cnt_a, 8'd0);
    repeat (3) @(negedge clk);
    chk("s1_cnt3", cnt_a, 8'd3);
    @(negedge clk);
    chk("s1_regnt_gnt", gnt_a, 2'b01);
    chk("s1_regnt_cnt", cnt_a, 8'd0);
    chk("s1_regnt_wr", a.fifo_wr, 1'b1);
    @(negedge clk);
    chk("s1_drop_wr", a.fifo_wr, 1'b0);
    @(negedge clk);
    chk("s1_back_idle", gnt_a, 2'b00);
    drain(8);

    // Contention from reset: 4 + 4 + 4 words, back to back.
    do_reset();
    for (int i = 0; i < 8; i++) rq0.push_back(8'(i));
    for (int i = 0; i < 4; i++) rq1.push_back(8'h80 | 8'(i));
    for (int i = 0; i < 4; i++) expect_a(8'(i));
    for (int i = 0; i < 4; i++) expect_a(8'h80 | 8'(i));
    for (int i = 4; i < 8; i++) expect_a(8'(i));
    rd_en = 1'b1;
    apply();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("s2_no_gap", a.fifo_wr, 1'b1);
      if (i == 0) chk("s2_first_gnt0", gnt_a, 2'b01);
      if (i == 4) begin chk("s2_gnt1", gnt_a, 2'b10); chk("s2_gnt1_cnt", cnt_a, 8'd0); end
      if (i == 8) begin chk("s2_gnt0_again", gnt_a, 2'b01); chk("s2_cnt", cnt_a, 8'd0); end
    end
    drain(6);

    // Full stall: req0 fills the FIFO, req1 waits, one read lets one word in.
    do_reset();
    for (int i = 0; i < 10; i++) begin rq0.push_back(8'h30 + 8'(i)); expect_a(8'h30 + 8'(i)); end
    apply();
    rst = 1'b0;
    repeat (9) @(negedge clk);
    chk("s3_full_nowr", a.fifo_wr, 1'b0);
    chk("s3_full_rdy0", a.req0_ready, 1'b0);
    #1;
    rq1.push_back(8'h40); expect_a(8'h40);
    apply();
    @(negedge clk);
    chk("s3_hold_gnt", gnt_a, 2'b01);
    chk("s3_hold_cnt", cnt_a, 8'd0);
    chk("s3_rdy1", a.req1_ready, 1'b0);
    chk("s3_nowr2", a.fifo_wr, 1'b0);
    #1 rd_pulse = 1'b1;
    @(negedge clk);
    #1 rd_pulse = 1'b0;
    nw = 0;
    repeat (3) begin @(negedge clk); nw += int'(a.fifo_wr); end
    chk("s3_one_word", nw, 1);
    chk("s3_cnt_after", cnt_a, 8'd1);
    drain(20);

    // Valid drop mid-burst hands the grant over with a fresh count.
    do_reset();
    rq1 = '{8'h50, 8'h51};
    expect_a(8'h50); expect_a(8'h51); expect_a(8'h60); expect_a(8'h61);
    rd_en = 1'b1;
    apply();
    rst = 1'b0;
    @(negedge clk);
    chk("s4_gnt1", gnt_a, 2'b10);
    #1;
    rq0 = '{8'h60, 8'h61};
    apply();
    repeat (2) @(negedge clk);
    chk("s4_drop_gnt", gnt_a, 2'b10);
    chk("s4_drop_cnt", cnt_a, 8'd2);
    chk("s4_drop_nowr", a.fifo_wr, 1'b0);
    @(negedge clk);
    chk("s4_next_gnt0", gnt_a, 2'b01);
    chk("s4_next_cnt", cnt_a, 8'd0);
    drain(6);

    // Reset during the second word of a GNT1 burst.
    do_reset();
    for (int i = 0; i < 8; i++) rq0.push_back(8'h70 + 8'(i));
    for (int i = 0; i < 5; i++) rq1.push_back(8'h90 + 8'(i));
    for (int i = 0; i < 4; i++) expect_a(8'h70 + 8'(i));
    expect_a(8'h90);
    for (int i = 4; i < 8; i++) expect_a(8'h70 + 8'(i));
    for (int i = 1; i < 5; i++) expect_a(8'h90 + 8'(i));
    rd_en = 1'b1;
    apply();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("s5_gnt1", gnt_a, 2'b10);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("s5_rst_gnt", gnt_a, 2'b00);
    chk("s5_rst_wr", a.fifo_wr, 1'b0);
    chk("s5_rst_rdy", {a.req0_ready, a.req1_ready}, 2'b00);
    chk("s5_rst_data", a.fifo_data, 8'h00);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("s5_idle", gnt_a, 2'b00);
    chk("s5_idle_cnt", cnt_a, 8'd0);
    @(negedge clk);
    chk("s5_gnt0", gnt_a, 2'b01);
    chk("s5_gnt0_cnt", cnt_a, 8'd0);
    drain(14);

    // BURST=1: strict word-by-word alternation, with periodic full stalls.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exp_b.push_back(8'(i));
      exp_b.push_back(8'h80 | 8'(i));
    end
    kb0 = 8'd0; kb1 = 8'd0; en_b = 1'b1;
    apply();
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("b_all_written", exp_b.size(), 0);
    chk("b_idle_end", gnt_b, 2'b00);
    #1 en_b = 1'b0;
    apply();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
